// File: rtl/mem_copy_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_pkg
// Shared types and constants for the MEMCOPY word-copy engine.
//   mc_state_t   : engine FSM state encoding
//   OPC_MEMCOPY  : opcode of the MEMCOPY instruction (decoded upstream)
//   WORD_BYTES   : byte stride between consecutive words
// -----------------------------------------------------------------------------
package mem_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mc_state_t;

    localparam logic [6:0] OPC_MEMCOPY = 7'b0001000;
    localparam int         WORD_BYTES  = 4;

endpackage

// File: rtl/mem_copy_engine_if.sv
// -----------------------------------------------------------------------------
// mem_copy_engine_if
// Data-memory port owned by the copy engine while it is busy.
//   mem_rdata  : read data from memory (combinational read)
//   mem_sel    : engine drives the data-memory port
//   mem_addr   : byte address
//   mem_wdata  : write data
//   mem_read   : read strobe
//   mem_write  : write strobe (memory writes on the rising clk edge)
// Modports: master = copy engine, slave = memory / datapath mux.
// -----------------------------------------------------------------------------
interface mem_copy_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;

    modport master (
        input  mem_rdata,
        output mem_sel,
        output mem_addr,
        output mem_wdata,
        output mem_read,
        output mem_write
    );

    modport slave (
        output mem_rdata,
        input  mem_sel,
        input  mem_addr,
        input  mem_wdata,
        input  mem_read,
        input  mem_write
    );
endinterface

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Multi-cycle word copier for the MEMCOPY instruction. On the decoder's start
// flag it latches src/dst/len and copies len words, one READ cycle followed by
// one WRITE cycle per word, in strictly ascending order. The PC is stalled
// until the copy finishes; done pulses for one cycle at the end.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   start     : decoder memcopy flag
//   src_addr  : source byte address, word aligned
//   dst_addr  : destination byte address, word aligned
//   len       : number of words to copy
//   mem       : data-memory port (master side)
//   stall     : freeze PC and register-file write
//   done      : one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [LEN_W-1:0]   len,
    mem_copy_engine_if.master  mem,
    output logic               stall,
    output logic               done
);

    mc_state_t          r_state;
    mc_state_t          w_next_state;
    logic [ADDR_W-1:0]  r_src_ptr;
    logic [ADDR_W-1:0]  r_dst_ptr;
    logic [LEN_W-1:0]   r_remaining;
    logic [DATA_W-1:0]  r_buf;

    // State, pointers and word counter. Inputs are sampled only on the
    // IDLE->busy edge; pointer arithmetic wraps silently modulo 2**ADDR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src_ptr   <= src_addr;
                        r_dst_ptr   <= dst_addr;
                        r_remaining <= len;
                    end
                end
                WRITE: begin
                    r_src_ptr   <= r_src_ptr + ADDR_W'(WORD_BYTES);
                    r_dst_ptr   <= r_dst_ptr + ADDR_W'(WORD_BYTES);
                    r_remaining <= r_remaining - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Word buffer is pure data: it needs no reset because it is only
    // observable in WRITE, which is always preceded by a capturing READ.
    always_ff @(posedge clk) begin
        if (r_state == READ) begin
            r_buf <= mem.mem_rdata;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        mem.mem_sel   = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        stall         = 1'b0;
        done          = 1'b0;
        case (r_state)
            IDLE: begin
                // Combinational stall so the PC never moves past MEMCOPY;
                // gated by reset so every output is low while reset is held.
                stall = start & ~reset;
                if (start) begin
                    w_next_state = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                mem.mem_sel  = 1'b1;
                mem.mem_read = 1'b1;
                mem.mem_addr = r_src_ptr;
                stall        = 1'b1;
                w_next_state = WRITE;
            end
            WRITE: begin
                mem.mem_sel   = 1'b1;
                mem.mem_write = 1'b1;
                mem.mem_addr  = r_dst_ptr;
                mem.mem_wdata = r_buf;
                stall         = 1'b1;
                w_next_state  = (r_remaining == LEN_W'(1)) ? DONE : READ;
            end
            DONE: begin
                // start is still high for the same instruction here; ignore it.
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
// Directed bench for mem_copy_engine with a scoreboard of expected memory
// transactions (read, write, done) and a word-addressed memory model.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

    typedef struct {
        logic [1:0]  kind;   // 0 = read, 1 = write, 2 = done
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        stall;
    logic        done;

    logic [31:0] mem [0:255];
    logic        bd_fill;
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    txn_t sb[$];
    int   n_checks;
    int   n_errors;

    mem_copy_engine_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .mem      (mif),
        .stall    (stall),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge, plus a backdoor.
    assign mif.mem_rdata = mem[mif.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hF000_0000 | i;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mif.mem_sel && mif.mem_write) begin
            mem[mif.mem_addr[9:2]] <= mif.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.kind = k;
        t.addr = a;
        t.data = d;
        sb.push_back(t);
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = val;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Monitor: every cycle showing a strobe or done must match the head of the queue.
    initial begin
        txn_t        e;
        logic [1:0]  k;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (!reset && (mif.mem_read || mif.mem_write || done)) begin
                k = done ? 2'd2 : (mif.mem_write ? 2'd1 : 2'd0);
                d = mif.mem_write ? mif.mem_wdata : (mif.mem_read ? mif.mem_rdata : 32'h0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_txn: kind %0d addr 0x%08h with empty queue", k, mif.mem_addr);
                end else begin
                    e = sb.pop_front();
                    check("txn_kind", {30'd0, k}, {30'd0, e.kind});
                    if (e.kind != 2'd2) begin
                        check("txn_addr", mif.mem_addr, e.addr);
                        check("txn_data", d, e.data);
                        check("txn_sel", {31'd0, mif.mem_sel}, 32'd1);
                        check("txn_stall", {31'd0, stall}, 32'd1);
                    end else begin
                        check("done_sel", {31'd0, mif.mem_sel}, 32'd0);
                    end
                end
            end
        end
    end

    // Launches one copy and follows it to done. With hold set, start stays high
    // through DONE and the operand inputs are scrambled mid-copy.
    task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input int exp_lat, input bit hold);
        int cyc;
        int stall_cnt;
        bit seen;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        #1 stall_cnt = stall ? 1 : 0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < exp_lat + 8) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (stall) stall_cnt++;
            if (!hold) begin
                start = 1'b0;
            end else if (cyc == 2) begin
                src_addr = 32'h0000_03F0;
                dst_addr = 32'h0000_03F8;
                len      = 16'd7;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_stall_cycles"}, stall_cnt, exp_lat);
        check({name, "_stall_at_done"}, {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({name, "_done_once"}, {31'd0, done}, 32'd0);
        check({name, "_idle_stall"}, {31'd0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        bd_fill  = 1'b1;
        bd_we    = 1'b0;
        bd_idx   = '0;
        bd_data  = '0;
        repeat (2) @(posedge clk);
        #1 bd_fill = 1'b0;
        start = 1'b1;
        #1;
        check("rst_mem_sel", {31'd0, mif.mem_sel}, 32'd0);
        check("rst_mem_read", {31'd0, mif.mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mif.mem_write}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // 1. Single word
        poke(8'd4, 32'hDEAD_BEEF);
        push(2'd0, 32'h10, 32'hDEAD_BEEF);
        push(2'd1, 32'h40, 32'hDEAD_BEEF);
        push(2'd2, 32'h0, 32'h0);
        run_copy("t1", 32'h10, 32'h40, 16'd1, 3, 1'b0);
        check("t1_mem40", mem[16], 32'hDEAD_BEEF);

        // 2. Four words
        poke(8'd0, 32'h1111_1111);
        poke(8'd1, 32'h2222_2222);
        poke(8'd2, 32'h3333_3333);
        poke(8'd3, 32'h4444_4444);
        push(2'd0, 32'h00, 32'h1111_1111); push(2'd1, 32'h80, 32'h1111_1111);
        push(2'd0, 32'h04, 32'h2222_2222); push(2'd1, 32'h84, 32'h2222_2222);
        push(2'd0, 32'h08, 32'h3333_3333); push(2'd1, 32'h88, 32'h3333_3333);
        push(2'd0, 32'h0C, 32'h4444_4444); push(2'd1, 32'h8C, 32'h4444_4444);
        push(2'd2, 32'h0, 32'h0);
        run_copy("t2", 32'h00, 32'h80, 16'd4, 9, 1'b0);
        check("t2_mem80", mem[32], 32'h1111_1111);
        check("t2_mem8C", mem[35], 32'h4444_4444);

        // 3. Zero length
        push(2'd2, 32'h0, 32'h0);
        run_copy("t3", 32'h200, 32'h300, 16'd0, 1, 1'b0);
        check("t3_mem300", mem[192], 32'hF000_00C0);

        // 4. Reset during the second WRITE
        poke(8'd64, 32'hAAAA_0000);
        poke(8'd65, 32'hAAAA_0001);
        push(2'd0, 32'h100, 32'hAAAA_0000);
        push(2'd1, 32'h180, 32'hAAAA_0000);
        push(2'd0, 32'h104, 32'hAAAA_0001);
        @(negedge clk);
        src_addr = 32'h100;
        dst_addr = 32'h180;
        len      = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t4_in_write2", {31'd0, mif.mem_write}, 32'd1);
        check("t4_write2_addr", mif.mem_addr, 32'h184);
        reset = 1'b1;
        #1;
        check("t4_rst_sel", {31'd0, mif.mem_sel}, 32'd0);
        check("t4_rst_write", {31'd0, mif.mem_write}, 32'd0);
        check("t4_rst_stall", {31'd0, stall}, 32'd0);
        check("t4_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_word0", mem[96], 32'hAAAA_0000);
        check("t4_word1", mem[97], 32'hF000_0061);
        check("t4_sb_empty", sb.size(), 0);

        // 5. start held through DONE, inputs changed mid-copy
        poke(8'd8, 32'h5555_0001);
        poke(8'd9, 32'h5555_0002);
        push(2'd0, 32'h20, 32'h5555_0001); push(2'd1, 32'h60, 32'h5555_0001);
        push(2'd0, 32'h24, 32'h5555_0002); push(2'd1, 32'h64, 32'h5555_0002);
        push(2'd2, 32'h0, 32'h0);
        run_copy("t5", 32'h20, 32'h60, 16'd2, 5, 1'b1);
        check("t5_mem60", mem[24], 32'h5555_0001);
        check("t5_mem64", mem[25], 32'h5555_0002);
        check("t5_mem3F8", mem[254], 32'hF000_00FE);

        // 6. Forward overlap
        poke(8'd0, 32'hA0A0_A0A0);
        poke(8'd1, 32'hB0B0_B0B0);
        poke(8'd2, 32'hC0C0_C0C0);
        push(2'd0, 32'h0, 32'hA0A0_A0A0); push(2'd1, 32'h4, 32'hA0A0_A0A0);
        push(2'd0, 32'h4, 32'hA0A0_A0A0); push(2'd1, 32'h8, 32'hA0A0_A0A0);
        push(2'd0, 32'h8, 32'hA0A0_A0A0); push(2'd1, 32'hC, 32'hA0A0_A0A0);
        push(2'd2, 32'h0, 32'h0);
        run_copy("t6", 32'h0, 32'h4, 16'd3, 7, 1'b0);
        check("t6_mem4", mem[1], 32'hA0A0_A0A0);
        check("t6_mem8", mem[2], 32'hA0A0_A0A0);
        check("t6_memC", mem[3], 32'hA0A0_A0A0);

        // 7. Source pointer wraps past the top of the address space
        push(2'd0, 32'hFFFF_FFFC, 32'hF000_00FF); push(2'd1, 32'h3C0, 32'hF000_00FF);
        push(2'd0, 32'h0000_0000, 32'hA0A0_A0A0); push(2'd1, 32'h3C4, 32'hA0A0_A0A0);
        push(2'd2, 32'h0, 32'h0);
        run_copy("t7", 32'hFFFF_FFFC, 32'h3C0, 16'd2, 5, 1'b0);
        check("t7_mem3C0", mem[240], 32'hF000_00FF);
        check("t7_mem3C4", mem[241], 32'hA0A0_A0A0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
